link_rx_buffer: RTL and testbench

//   Receive-side buffer at the far end of a fixed-latency link modelled by the harness delay line.
//   The link has no backpressure, so this block captures every arriving flit into a DEPTH-entry FIFO.
//   It presents the flits to the consumer over valid/ready.
//   For each flit popped it returns one credit pulse, which the harness delays back to the sender.
//   A sender starting with DEPTH credits can then never overflow the buffer.

---
 rtl/noc_harness_pkg.sv | 17 +
 rtl/link_rx_storage.sv | 24 ++
 rtl/link_rx_buffer.sv | 100 ++++++++++
 tb/tb_link_rx_buffer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/noc_harness_pkg.sv
// Shared harness types and helpers for the link receive path.
// Contains the pointer-width helper and the status record that the bench monitor packs.
package noc_harness_pkg;

    localparam int STATUS_OCC_W = 8;

    typedef struct packed {
        logic                    overflow_err;
        logic [STATUS_OCC_W-1:0] occupancy;
    } rx_status_t;

    // Pointer width for a DEPTH-entry array; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/link_rx_storage.sv
// DEPTH x WIDTH register array: one write port, one asynchronous read port.
// The data is deliberately not reset; validity is tracked by the owner's occupancy.
module link_rx_storage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/link_rx_buffer.sv
// Credit-returning receive FIFO at the far end of a fixed-latency, no-backpressure link.
// Define LINK_RX_BYPASS_EN for a same-cycle fall-through path while the buffer is empty.
module link_rx_buffer
    import noc_harness_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       credit_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             credit_q, credit_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, bypass, pop, push, wr_en, rd_en;
    logic [WIDTH-1:0] rdata;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty = (occ_q == '0);
        full  = (occ_q == FULL_OCC);
`ifdef LINK_RX_BYPASS_EN
        bypass    = empty && in_valid;
        out_valid = !empty || in_valid;
        out_data  = empty ? in_data : rdata;
`else
        bypass    = 1'b0;
        out_valid = !empty;
        out_data  = rdata;
`endif
        pop  = out_valid && out_ready;
        push = in_valid && (!full || pop);
        // A bypassed flit that is consumed immediately never touches the array.
        wr_en = push && !(bypass && pop);
        rd_en = pop && !bypass;

        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        credit_d = pop;
        ovf_d    = ovf_q || (in_valid && !push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    link_rx_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign occupancy    = occ_q;
    assign credit_out   = credit_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_link_rx_buffer.sv
// Bench for link_rx_buffer: DEPTH=8 and DEPTH=5 instances checked against a queue model.
// Follows LINK_RX_BYPASS_EN so the model matches whichever build is compiled.
module tb_link_rx_buffer;
    import noc_harness_pkg::*;

`ifdef LINK_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv8, ordy8, ov8, cr8, oe8;
    logic        iv5, ordy5, ov5, cr5, oe5;
    logic [31:0] id8, od8, id5, od5;
    logic [3:0]  occ8;
    logic [2:0]  occ5;

    link_rx_buffer #(.WIDTH(32), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_data(id8),
        .out_valid(ov8), .out_data(od8), .out_ready(ordy8),
        .credit_out(cr8), .occupancy(occ8), .overflow_err(oe8)
    );

    link_rx_buffer #(.WIDTH(32), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_data(id5),
        .out_valid(ov5), .out_data(od5), .out_ready(ordy5),
        .credit_out(cr5), .occupancy(occ5), .overflow_err(oe5)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    int          cap;
    int          sel;
    bit          exp_cr, exp_ovf;
    int          pops, credits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the selected instance; outputs checked before the edge.
    task automatic step(input bit v, input logic [31:0] d, input bit r, input bit rs);
        bit          ev, hit, pop, push;
        logic        ov, cr, oe;
        logic [31:0] od, occ;
        @(negedge clk);
        rst = rs;
        if (sel == 0) begin iv8 = v; id8 = d; ordy8 = r; end
        else          begin iv5 = v; id5 = d; ordy5 = r; end
        #1;
        if (sel == 0) begin ov = ov8; od = od8; occ = 32'(occ8); cr = cr8; oe = oe8; end
        else          begin ov = ov5; od = od5; occ = 32'(occ5); cr = cr5; oe = oe5; end
        hit = BYP && (mq.size() == 0) && v;
        ev  = (mq.size() != 0) || hit;
        chk("out_valid", 32'(ov), 32'(ev));
        if (ev) chk("out_data", od, (mq.size() != 0) ? mq[0] : d);
        chk("occupancy", occ, mq.size());
        chk("credit_out", 32'(cr), 32'(exp_cr));
        chk("overflow_err", 32'(oe), 32'(exp_ovf));
        if (cr === 1'b1) credits++;
        pop  = ev && r;
        push = v && ((mq.size() < cap) || pop);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            exp_cr  = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            exp_cr = pop;
            if (pop) pops++;
            if (pop && !hit) void'(mq.pop_front());
            if (push && !(pop && hit)) mq.push_back(d);
            if (v && !push) exp_ovf = 1'b1;
        end
    endtask

    initial begin
        rx_status_t st;
        rst = 1'b1;
        iv8 = 0; ordy8 = 0; id8 = '0;
        iv5 = 0; ordy5 = 0; id5 = '0;
        sel = 0; cap = 8; exp_cr = 0; exp_ovf = 0; pops = 0; credits = 0;
        repeat (2) @(posedge clk);

        // Idle after reset.
        repeat (5) step(0, '0, 0, 0);

        // Fill to 8 with the consumer stalled, then drain in order.
        for (int i = 0; i < 8; i++) step(1, 32'h11 + 32'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Full with simultaneous arrival and pop.
        for (int i = 0; i < 8; i++) step(1, 32'h21 + 32'(i), 0, 0);
        step(1, 32'hAA, 1, 0);

        // Full with arrival and no pop: dropped, sticky error survives the drain.
        step(1, 32'hBB, 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        repeat (2) step(0, '0, 0, 0);

        // Reset both, switch to the DEPTH=5 instance.
        step(0, '0, 0, 1);
        sel = 1; cap = 5; pops = 0; credits = 0;

        // Random traffic through pointer wrap.
        for (int i = 0; i < 23; i++)
            step(($urandom_range(9) < 7), $urandom, $urandom_range(1) == 1, 0);
        step(0, '0, 0, 0);
        chk("credits_eq_pops", credits, pops);

        // Reset with entries held: everything discarded, no credit.
        step(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h31 + 32'(i), 0, 0);
        step(0, '0, 1, 1);
        step(0, '0, 0, 0);

        // Empty with arrival and ready: fall-through when bypass is built in.
        step(1, 32'h5A, 1, 0);
        step(0, '0, 0, 0);

        #1;
        st.overflow_err = oe5;
        st.occupancy    = STATUS_OCC_W'(occ5);
        chk("status", 32'(st), 32'({exp_ovf, STATUS_OCC_W'(mq.size())}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
